ewb_coalesce: RTL and testbench
===============================

Name: ewb_coalesce

Overview:
- Parametrised eviction write buffer between the L2 cache and physical memory. It queues dirty victim lines, in order, for write-back.
- Generalises the earlier single-purpose buffer:
  - configurable line, address and depth
  - address returned on the drain side
  - true simultaneous enqueue and dequeue
  - youngest-match snoop lookup
  - optional write-coalescing of repeated evictions to the same line

Parameters:
- WIDTH, 256, line width in bits.
- ADDR_W, 32, address width.
- OFFSET, 5, line-offset bits; tag width TAG_W = ADDR_W-OFFSET.
- DEPTH, 8, number of entries; must be a power of 2 and ≥2. PTR_W = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
- enq_valid_i  in  1  victim line offered.
- enq_ready_o  out  1  buffer accepts the offered line this cycle.
- enq_addr_i  in  ADDR_W  victim line address; low OFFSET bits ignored.
- enq_data_i  in  WIDTH  victim line data.
- lookup_valid_i  in  1  snoop request.
- lookup_tag_i  in  TAG_W  snoop tag (addr[ADDR_W-1:OFFSET]).
- hit_o  out  1  snoop hit.
- hit_data_o  out  WIDTH  data of the youngest matching entry; '0 on miss.
- deq_valid_o  out  1  head entry available.
- deq_ready_i  in  1  memory side takes head.
- deq_addr_o  out  ADDR_W  head address, with offset bits forced to 0.
- deq_data_o  out  WIDTH  head data.
- count_o  out  PTR_W+1  occupied entries, 0..DEPTH.
- full_o  out  1  count_o==DEPTH.
- empty_o  out  1  count_o==0.

Behaviour:
- Storage and state:
  - Circular array of DEPTH entries {tag, data}.
  - rd_ptr and wr_ptr are PTR_W bits and wrap naturally at DEPTH.
  - count is PTR_W+1 bits.
- Reset (rst low, async):
  - rd_ptr, wr_ptr and count are cleared.
  - Entry contents are don't-care.
  - Outputs during and after reset: enq_ready_o=1, deq_valid_o=0, hit_o=0, hit_data_o=0, count_o=0, full_o=0, empty_o=1.
  - Reset asserted mid-transfer discards all entries; no partial line is ever presented afterwards.
- Handshakes:
  - enq_fire = enq_valid_i & enq_ready_o.
  - deq_fire = deq_valid_o & deq_ready_i.
  - deq_valid_o = !empty_o.
  - deq_addr_o and deq_data_o are driven combinationally from the head entry, with no bypass: a line enqueued in cycle N is first visible at the head in cycle N+1.
  - The head entry is stable while deq_valid_o=1 and deq_ready_i=0.
- Allocation (no coalesce):
  - enq_fire writes entry[wr_ptr] and advances wr_ptr.
  - deq_fire advances rd_ptr.
  - count += enq_alloc - deq_fire. Both in one cycle: both pointers move and count is unchanged.
- enq_ready_o:
  - Base rule: enq_ready_o = !full_o. It has no combinational dependence on deq_ready_i; full plus a dequeue in the same cycle still refuses the enqueue.
- Lookup:
  - Purely combinational.
  - Scans valid entries only (oldest to youngest, i < count). The youngest match drives hit_data_o.
  - Sees pre-edge state: a same-cycle enqueue is not visible; a same-cycle dequeued head is still visible.
  - hit_o=0 when lookup_valid_i=0.
- Boundaries:
  - Pointer wrap DEPTH-1 -> 0 is seamless.
  - count never exceeds DEPTH or underflows.
  - deq_ready_i while empty has no effect.

Optional Feature:
- Macro: EWB_COALESCE_EN.
- Defined:
  - An enqueue whose tag matches a valid non-head entry overwrites that entry's data in place. Pointers and count are unchanged.
  - It is accepted even when full: enq_ready_o = !full_o | coalesce_match.
  - The head is never a coalesce target, so it always allocates a new entry. Head stability under back-pressure holds.
  - Invariant: at most one non-head entry per tag.
- Undefined: every enqueue allocates. enq_ready_o = !full_o. Duplicate tags may coexist; lookup returns the youngest.

Test Plan:
- Fill and drain, DEPTH=8:
  - Enqueue 8 lines, addr 0x1000+0x20*i, data i; full_o=1 and enq_ready_o=0 after the 8th.
  - Then drain: deq_addr_o sequence is 0x1000..0x10E0 and deq_data_o is 0..7; empty_o=1 at the end.
- Simultaneous, count=3:
  - enq_fire and deq_fire in the same cycle -> count_o stays 3.
  - Repeated 20 cycles across pointer wrap -> in-order data, no loss.
- Snoop:
  - Enqueue tag 0x80 with data A, then tag 0x80 with data B (coalesce off).
  - Lookup 0x80 -> hit_o=1, hit_data_o=B. Lookup 0x81 -> hit_o=0, hit_data_o=0.
  - Lookup in the cycle of enqueueing tag 0x90 -> miss.
- Back-pressure:
  - deq_ready_i=0 for 10 cycles with entries present -> deq_addr_o and deq_data_o unchanged.
  - Under EWB_COALESCE_EN, an enqueue matching the head tag allocates a new entry (count+1) and the head is unchanged.
- Coalesce (EWB_COALESCE_EN), buffer full with a non-head entry of tag 0x44:
  - Enqueue tag 0x44 with data C -> accepted, count_o stays 8.
  - When drained, that slot carries C.
- Reset:
  - Assert rst low asynchronously mid-stream with count 5 -> immediately deq_valid_o=0 and count_o=0.
  - After release, first enqueue then dequeue returns the new line only.

Source files
------------

// File: rtl/ewb_coalesce_if.sv
// Bus bundle for the eviction write buffer: enqueue, snoop lookup, drain and occupancy status.
// The slave modport is the buffer side; the master modport is the cache/memory side.
interface ewb_coalesce_if #(
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 32,
  parameter int OFFSET = 5,
  parameter int DEPTH  = 8
);
  localparam int TAG_W = ADDR_W - OFFSET;
  localparam int PTR_W = $clog2(DEPTH);

  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [ADDR_W-1:0] enq_addr_i;
  logic [WIDTH-1:0]  enq_data_i;
  logic              lookup_valid_i;
  logic [TAG_W-1:0]  lookup_tag_i;
  logic              hit_o;
  logic [WIDTH-1:0]  hit_data_o;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [ADDR_W-1:0] deq_addr_o;
  logic [WIDTH-1:0]  deq_data_o;
  logic [PTR_W:0]    count_o;
  logic              full_o;
  logic              empty_o;

  modport master (
    output enq_valid_i, enq_addr_i, enq_data_i, lookup_valid_i, lookup_tag_i, deq_ready_i,
    input  enq_ready_o, hit_o, hit_data_o, deq_valid_o, deq_addr_o, deq_data_o,
           count_o, full_o, empty_o
  );

  modport slave (
    input  enq_valid_i, enq_addr_i, enq_data_i, lookup_valid_i, lookup_tag_i, deq_ready_i,
    output enq_ready_o, hit_o, hit_data_o, deq_valid_o, deq_addr_o, deq_data_o,
           count_o, full_o, empty_o
  );
endinterface

// File: rtl/ewb_coalesce.sv
// In-order eviction write buffer with youngest-match snoop lookup.
// Define EWB_COALESCE_EN to merge repeated evictions of a queued non-head line in place.
module ewb_coalesce #(
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 32,
  parameter int OFFSET = 5,
  parameter int DEPTH  = 8
) (
  input logic           clk,
  input logic           rst,
  ewb_coalesce_if.slave bus
);
  localparam int TAG_W = ADDR_W - OFFSET;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [TAG_W-1:0] enq_tag;
  logic             full, empty;
  logic             enq_ready, deq_valid;
  logic             enq_fire, deq_fire, enq_alloc;
  logic             coalesce_match;
  logic             hit;
  logic [WIDTH-1:0] hit_data;
  logic             unused_offset;

  assign enq_tag       = bus.enq_addr_i[ADDR_W-1:OFFSET];
  assign unused_offset = ^bus.enq_addr_i[OFFSET-1:0];

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign enq_ready = !full || coalesce_match;
  assign deq_valid = !empty;
  assign enq_fire  = bus.enq_valid_i && enq_ready;
  assign deq_fire  = deq_valid && bus.deq_ready_i;
  assign enq_alloc = enq_fire && !coalesce_match;

`ifdef EWB_COALESCE_EN
  logic [PTR_W-1:0] coalesce_idx;

  // The head is skipped (i starts at 1) so a line being drained is never modified.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    coalesce_match = 1'b0;
    coalesce_idx   = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count_q && tag_q[rd_ptr_q + PTR_W'(i)] == enq_tag) begin
        coalesce_match = 1'b1;
        coalesce_idx   = rd_ptr_q + PTR_W'(i);
      end
    end
  end
`else
  assign coalesce_match = 1'b0;
`endif

  // Oldest-to-youngest scan; later matches overwrite earlier ones so the youngest wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (bus.lookup_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((PTR_W+1)'(i) < count_q && tag_q[rd_ptr_q + PTR_W'(i)] == bus.lookup_tag_i) begin
          hit      = 1'b1;
          hit_data = data_q[rd_ptr_q + PTR_W'(i)];
        end
      end
    end
  end

  assign rd_ptr_d = rd_ptr_q + PTR_W'(deq_fire);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(enq_alloc);
  assign count_d  = count_q + (PTR_W+1)'(enq_alloc) - (PTR_W+1)'(deq_fire);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
`ifdef EWB_COALESCE_EN
    if (enq_fire && coalesce_match) begin
      data_q[coalesce_idx] <= bus.enq_data_i;
    end
`endif
    if (enq_alloc) begin
      tag_q[wr_ptr_q]  <= enq_tag;
      data_q[wr_ptr_q] <= bus.enq_data_i;
    end
  end

  assign bus.enq_ready_o = enq_ready;
  assign bus.deq_valid_o = deq_valid;
  assign bus.deq_addr_o  = {tag_q[rd_ptr_q], {OFFSET{1'b0}}};
  assign bus.deq_data_o  = data_q[rd_ptr_q];
  assign bus.hit_o       = hit;
  assign bus.hit_data_o  = hit_data;
  assign bus.count_o     = count_q;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
endmodule

// File: tb/tb_ewb_coalesce.sv
// Self-checking bench for ewb_coalesce: table-driven fill/drain, directed corner cases and
// randomized traffic against a queue-based reference model (both EWB_COALESCE_EN settings).
module tb_ewb_coalesce;
  localparam int WIDTH  = 256;
  localparam int ADDR_W = 32;
  localparam int OFFSET = 5;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = ADDR_W - OFFSET;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ewb_coalesce_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .OFFSET(OFFSET), .DEPTH(DEPTH)) bus ();

  ewb_coalesce #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .OFFSET(OFFSET), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } entry_t;
  entry_t m_q[$];

  typedef struct {
    logic             enq_v;
    logic [31:0]      enq_addr;
    logic [31:0]      enq_data;
    logic             deq_r;
    logic             lk_v;
    logic [TAG_W-1:0] lk_tag;
    int               exp_count;
    logic             exp_ready;
    logic             exp_full;
    logic             exp_dvalid;
    logic [31:0]      exp_daddr;
    logic [31:0]      exp_ddata;
    logic             exp_hit;
    logic [31:0]      exp_hdata;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_coal_idx(input logic [TAG_W-1:0] t);
    int r;
    r = -1;
`ifdef EWB_COALESCE_EN
    for (int j = m_q.size() - 1; j >= 1; j--) begin
      if (r < 0 && m_q[j].tag == t) r = j;
    end
`else
    if (t === 'x) r = -1;
`endif
    return r;
  endfunction

  task automatic model_check();
    int n;
    int ci;
    logic             exp_hit;
    logic [WIDTH-1:0] exp_hd;
    n  = m_q.size();
    ci = m_coal_idx(bus.enq_addr_i[ADDR_W-1:OFFSET]);
    check("count", bus.count_o, n);
    check("full", bus.full_o, n == DEPTH);
    check("empty", bus.empty_o, n == 0);
    check("enq_ready", bus.enq_ready_o, (n < DEPTH) || (ci >= 0));
    check("deq_valid", bus.deq_valid_o, n > 0);
    if (n > 0) begin
      check("deq_addr", bus.deq_addr_o, {m_q[0].tag, {OFFSET{1'b0}}});
      check("deq_data", bus.deq_data_o, m_q[0].data);
    end
    exp_hit = 1'b0;
    exp_hd  = '0;
    if (bus.lookup_valid_i) begin
      foreach (m_q[j]) begin
        if (m_q[j].tag == bus.lookup_tag_i) begin
          exp_hit = 1'b1;
          exp_hd  = m_q[j].data;
        end
      end
    end
    check("hit", bus.hit_o, exp_hit);
    check("hit_data", bus.hit_data_o, exp_hd);
  endtask

  task automatic model_update();
    int  ci;
    bit  ef, df;
    entry_t e;
    ci = m_coal_idx(bus.enq_addr_i[ADDR_W-1:OFFSET]);
    ef = bus.enq_valid_i && ((m_q.size() < DEPTH) || (ci >= 0));
    df = (m_q.size() > 0) && bus.deq_ready_i;
    if (ef && ci >= 0) m_q[ci].data = bus.enq_data_i;
    if (df) void'(m_q.pop_front());
    if (ef && ci < 0) begin
      e.tag  = bus.enq_addr_i[ADDR_W-1:OFFSET];
      e.data = bus.enq_data_i;
      m_q.push_back(e);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic commit();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_valid_i    = 1'b0;
    bus.enq_addr_i     = '0;
    bus.enq_data_i     = '0;
    bus.deq_ready_i    = 1'b0;
    bus.lookup_valid_i = 1'b0;
    bus.lookup_tag_i   = '0;
  endtask

  task automatic push(input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] data);
    idle();
    bus.enq_valid_i = 1'b1;
    bus.enq_addr_i  = {tag, {OFFSET{1'b0}}};
    bus.enq_data_i  = data;
    settle();
    commit();
  endtask

  task automatic drain();
    idle();
    bus.deq_ready_i = 1'b1;
    for (int k = 0; k < 4 * DEPTH && m_q.size() > 0; k++) begin
      settle();
      commit();
    end
    idle();
    settle();
    check("drained_empty", bus.empty_o, 1'b1);
    commit();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill/drain vectors: line k at 0x1000+0x20*k carries data k; lookups snoop tag 0x81 (line 1).
    for (int r = 0; r < 18; r++) begin
      tbl[r] = '{enq_v: 1'b0, enq_addr: '0, enq_data: '0, deq_r: 1'b0, lk_v: 1'b1,
                 lk_tag: 27'h81, exp_count: 0, exp_ready: 1'b1, exp_full: 1'b0,
                 exp_dvalid: 1'b0, exp_daddr: '0, exp_ddata: '0, exp_hit: 1'b0, exp_hdata: '0};
    end
    tbl[0].lk_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tbl[k+1].enq_v      = 1'b1;
      tbl[k+1].enq_addr   = 32'h1000 + 32'h20 * k;
      tbl[k+1].enq_data   = k;
      tbl[k+1].exp_count  = k;
      tbl[k+1].exp_dvalid = (k > 0);
      tbl[k+1].exp_daddr  = (k > 0) ? 32'h1000 : 32'h0;
      tbl[k+1].exp_hit    = (k >= 2);
      tbl[k+1].exp_hdata  = (k >= 2) ? 32'd1 : 32'd0;
    end
    tbl[9].enq_v      = 1'b1;
    tbl[9].enq_addr   = 32'h2000;
    tbl[9].enq_data   = 32'h99;
    tbl[9].deq_r      = 1'b1;
    tbl[9].exp_count  = 8;
    tbl[9].exp_ready  = 1'b0;
    tbl[9].exp_full   = 1'b1;
    tbl[9].exp_dvalid = 1'b1;
    tbl[9].exp_daddr  = 32'h1000;
    tbl[9].exp_hit    = 1'b1;
    tbl[9].exp_hdata  = 32'd1;
    for (int j = 1; j < 8; j++) begin
      tbl[9+j].deq_r      = 1'b1;
      tbl[9+j].exp_count  = 8 - j;
      tbl[9+j].exp_dvalid = 1'b1;
      tbl[9+j].exp_daddr  = 32'h1000 + 32'h20 * j;
      tbl[9+j].exp_ddata  = j;
      tbl[9+j].exp_hit    = (j == 1);
      tbl[9+j].exp_hdata  = (j == 1) ? 32'd1 : 32'd0;
    end

    // Reset state, with a snoop active while reset is held.
    idle();
    bus.lookup_valid_i = 1'b1;
    bus.lookup_tag_i   = 27'h81;
    #2;
    check("rst_enq_ready", bus.enq_ready_o, 1'b1);
    check("rst_deq_valid", bus.deq_valid_o, 1'b0);
    check("rst_hit", bus.hit_o, 1'b0);
    check("rst_hit_data", bus.hit_data_o, '0);
    check("rst_count", bus.count_o, 0);
    check("rst_full", bus.full_o, 1'b0);
    check("rst_empty", bus.empty_o, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();

    for (int r = 0; r < 18; r++) begin
      bus.enq_valid_i    = tbl[r].enq_v;
      bus.enq_addr_i     = tbl[r].enq_addr;
      bus.enq_data_i     = WIDTH'(tbl[r].enq_data);
      bus.deq_ready_i    = tbl[r].deq_r;
      bus.lookup_valid_i = tbl[r].lk_v;
      bus.lookup_tag_i   = tbl[r].lk_tag;
      settle();
      check($sformatf("tbl%0d_count", r), bus.count_o, tbl[r].exp_count);
      check($sformatf("tbl%0d_ready", r), bus.enq_ready_o, tbl[r].exp_ready);
      check($sformatf("tbl%0d_full", r), bus.full_o, tbl[r].exp_full);
      check($sformatf("tbl%0d_dvalid", r), bus.deq_valid_o, tbl[r].exp_dvalid);
      if (tbl[r].exp_dvalid) begin
        check($sformatf("tbl%0d_daddr", r), bus.deq_addr_o, WIDTH'(tbl[r].exp_daddr));
        check($sformatf("tbl%0d_ddata", r), bus.deq_data_o, WIDTH'(tbl[r].exp_ddata));
      end
      check($sformatf("tbl%0d_hit", r), bus.hit_o, tbl[r].exp_hit);
      check($sformatf("tbl%0d_hdata", r), bus.hit_data_o, WIDTH'(tbl[r].exp_hdata));
      commit();
    end
    idle();

    // Snoop: duplicate tag returns the youngest data; same-cycle enqueue is invisible.
    push(27'h80, 256'hAAAA);
    push(27'h80, 256'hBBBB);
    idle();
    bus.lookup_valid_i = 1'b1;
    bus.lookup_tag_i   = 27'h80;
    settle();
    check("snoop_count", bus.count_o, 2);
    check("snoop_hit", bus.hit_o, 1'b1);
    check("snoop_data", bus.hit_data_o, 256'hBBBB);
    commit();
    bus.lookup_tag_i = 27'h81;
    settle();
    check("snoop_miss_hit", bus.hit_o, 1'b0);
    check("snoop_miss_data", bus.hit_data_o, '0);
    commit();
    bus.enq_valid_i  = 1'b1;
    bus.enq_addr_i   = {27'h90, 5'h1f};
    bus.enq_data_i   = 256'h9090;
    bus.lookup_tag_i = 27'h90;
    settle();
    check("snoop_same_cycle_miss", bus.hit_o, 1'b0);
    commit();
    bus.enq_valid_i = 1'b0;
    settle();
    check("snoop_next_cycle_hit", bus.hit_o, 1'b1);
    commit();
    drain();

    // Back-pressure: head holds for 10 cycles.
    push(27'h123, 256'h5151);
    push(27'h124, 256'h5252);
    idle();
    for (int k = 0; k < 10; k++) begin
      settle();
      check("bp_addr", bus.deq_addr_o, WIDTH'(32'h2460));
      check("bp_data", bus.deq_data_o, 256'h5151);
      commit();
    end
    drain();

    // Simultaneous enqueue/dequeue at count 3 across pointer wrap.
    for (int k = 0; k < 3; k++) push(27'h600 + 27'(k), WIDTH'(32'h600 + k));
    for (int k = 3; k < 23; k++) begin
      idle();
      bus.enq_valid_i = 1'b1;
      bus.enq_addr_i  = {27'h600 + 27'(k), {OFFSET{1'b0}}};
      bus.enq_data_i  = WIDTH'(32'h600 + k);
      bus.deq_ready_i = 1'b1;
      settle();
      check("simul_count", bus.count_o, 3);
      check("simul_data", bus.deq_data_o, WIDTH'(32'h600 + k - 3));
      commit();
    end
    drain();

`ifdef EWB_COALESCE_EN
    // Coalesce into a non-head entry while full.
    for (int k = 0; k < 8; k++) push(27'h40 + 27'(k), WIDTH'(32'h100 + k));
    idle();
    bus.enq_valid_i = 1'b1;
    bus.enq_addr_i  = {27'h44, {OFFSET{1'b0}}};
    bus.enq_data_i  = 256'hC;
    settle();
    check("coal_ready_full", bus.enq_ready_o, 1'b1);
    commit();
    idle();
    settle();
    check("coal_count", bus.count_o, 8);
    commit();
    bus.deq_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("coal_drain", bus.deq_data_o, (k == 4) ? 256'hC : WIDTH'(32'h100 + k));
      commit();
    end
    drain();

    // A head-tag enqueue under back-pressure allocates a new entry.
    push(27'h90, 256'h1);
    push(27'h91, 256'h2);
    push(27'h90, 256'h3);
    idle();
    settle();
    check("coal_head_count", bus.count_o, 3);
    check("coal_head_data", bus.deq_data_o, 256'h1);
    commit();
    drain();
`endif

    // Randomized traffic over a small tag space so duplicates and snoop hits are common.
    for (int k = 0; k < 400; k++) begin
      bus.enq_valid_i    = ($urandom_range(0, 99) < 60);
      bus.enq_addr_i     = {27'h40 + 27'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      bus.enq_data_i     = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
      bus.deq_ready_i    = ($urandom_range(0, 99) < 50);
      bus.lookup_valid_i = ($urandom_range(0, 99) < 70);
      bus.lookup_tag_i   = 27'h40 + 27'($urandom_range(0, 8));
      settle();
      commit();
    end
    drain();

    // Asynchronous reset mid-stream with five entries queued.
    for (int k = 0; k < 5; k++) push(27'h700 + 27'(k), WIDTH'(32'h700 + k));
    idle();
    bus.enq_valid_i    = 1'b1;
    bus.enq_addr_i     = {27'h705, {OFFSET{1'b0}}};
    bus.enq_data_i     = 256'h705;
    bus.lookup_valid_i = 1'b1;
    bus.lookup_tag_i   = 27'h700;
    bus.deq_ready_i    = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    m_q.delete();
    check("arst_deq_valid", bus.deq_valid_o, 1'b0);
    check("arst_count", bus.count_o, 0);
    check("arst_empty", bus.empty_o, 1'b1);
    check("arst_hit", bus.hit_o, 1'b0);
    check("arst_ready", bus.enq_ready_o, 1'b1);
    @(posedge clk);
    #1;
    check("arst_held_count", bus.count_o, 0);
    idle();
    rst = 1'b1;
    push(27'h180, 256'hBEEF);
    idle();
    bus.deq_ready_i = 1'b1;
    settle();
    check("post_rst_count", bus.count_o, 1);
    check("post_rst_data", bus.deq_data_o, 256'hBEEF);
    check("post_rst_addr", bus.deq_addr_o, WIDTH'(32'h3000));
    commit();
    idle();
    settle();
    check("post_rst_empty", bus.empty_o, 1'b1);
    commit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
